spi_cmd_framer: RTL and testbench
=================================

# spi_cmd_framer

Command framing stage between the ESP-facing SPI slave byte receiver and the FPGA action logic (LED, flash SPI shifter, screen color, status registers). It consumes the byte stream and chip-select framing pulses from the SPI slave, decodes each command byte against a fixed parameter-length table, and collects parameter bytes. It then issues a single-cycle `trigger_action` with a stable command and parameter set. Malformed traffic is reported through a sticky error code that the existing action logic can read back.

## Interface
Parameters:
- `MAX_PARAMS`, 5: parameter buffer depth in bytes. It must be at least 3 (the longest table entry).
- `TIMEOUT_CYCLES`, 16'd42000: maximum `clk` cycles allowed between bytes inside a frame. This is 500 µs at 84 MHz. Used only with `SPI_CMD_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, 84 MHz from the PLL.
- `reset` in 1: synchronous, active-high reset.
- `start_msg` in 1: one-cycle pulse on the CS assert edge.
- `byte_valid` in 1: one-cycle pulse when a full byte has been shifted in.
- `byte_in` in 8: received byte, valid while `byte_valid`=1.
- `error_clear` in 1: clears `err_code`.
- `trigger_action` out 1: one-cycle pulse when a command is complete.
- `cmd` out 8: last accepted command byte.
- `params` out 8*MAX_PARAMS: parameter bytes, with params[0] in bits [7:0].
- `busy` out 1: high while collecting parameters.
- `err_code` out 2: sticky error code. 00 none, 01 unknown command, 10 truncated frame, 11 inter-byte timeout.
- `trig_count` out 8: number of triggers issued, mod 256.

## Operation
Parameter-length table, by command byte:
- 0 bytes: 0, 15, 16, 27, 31.
- 3 bytes: 17.
- 1 byte: 26, 29, 30, 32, 33, 34.
- Any other byte: unknown command.

State machine, states IDLE and READ:
- IDLE, `byte_valid`:
  - `cmd`←`byte_in`, idx←0.
  - Length 0: pulse `trigger_action` and stay in IDLE.
  - Length n>0: remaining←n, go to READ.
  - Unknown command: `cmd` is still updated, no trigger, stay in IDLE, record error 01.
- READ, `byte_valid`:
  - params[idx]←`byte_in`, idx←idx+1.
  - If remaining==1: pulse `trigger_action` and go to IDLE. Otherwise remaining←remaining−1.
- `start_msg` in READ: abort to IDLE, record error 10, no trigger.
- `start_msg` in IDLE: no effect.
- `start_msg` and `byte_valid` in the same cycle: `start_msg` wins, the byte is dropped, and error 10 is recorded only if the state was READ.

Data-holding rules:
- `params` entries not written by the current command keep their old values.
- `params` and `cmd` stay stable from the trigger until the next command byte is accepted.
- `busy` = (state==READ).

Error register:
- Records the first error only. Later errors are ignored until `error_clear`.
- If `error_clear` and a new error occur in the same cycle, the new error is recorded.

`trig_count` increments on every `trigger_action` and wraps 255→0.

## Timing
- All outputs are registered.
- `trigger_action` is high for exactly the one cycle after the `byte_valid` of the final byte, whether that is the command byte or the last parameter.
- `cmd` updates the cycle after the command byte's `byte_valid`.
- `params[i]` updates the cycle after its byte's `byte_valid`, so it is valid no later than `trigger_action`.
- Back-to-back `byte_valid` on consecutive cycles must be accepted without loss.
- Reset values: state=IDLE, `trigger_action`=0, `cmd`=8'h00, `params`=0, `busy`=0, `err_code`=00, `trig_count`=0, timeout counter=0.
- A reset in the middle of a frame discards the frame with no trigger and no error.

## Configuration
- Macro `SPI_CMD_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on every `byte_valid` and on entry to READ, and increments every cycle in READ.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, record error 11, no trigger.
  - If the final byte arrives in the same cycle as the terminal count, the byte wins and the trigger is issued.
- Undefined: no counter is built and READ waits indefinitely. Code 11 is never produced.

## Test plan
- Command 8'h00 alone → `trigger_action` 1 cycle after its `byte_valid`, `cmd`=00, `trig_count`=1, `err_code`=00.
- Sequence 8'h11, A1, B2, C3 with `byte_valid` on consecutive cycles → a single trigger after C3, `params`[2:0]={C3,B2,A1}, `busy` high for 3 cycles.
- 8'h05 → no trigger, `err_code`=01. Then 8'h1A, 8'h07 → trigger with params[0]=07, `err_code` still 01. `error_clear` → 00.
- 8'h11, 55, then `start_msg` → no trigger, `err_code`=10, state IDLE. Then 8'h1E, 3C → trigger, `cmd`=1E, params[0]=3C.
- With `SPI_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: 8'h1D, then idle for 100 cycles → `err_code`=11, no trigger. Final byte at cycle 99 → trigger issued.
- 257 zero-param commands → `trig_count`=1. Reset asserted during READ → all outputs return to their reset values.

Source files
------------

// File: rtl/spi_cmd_framer.sv
// spi_cmd_framer: turns the SPI slave byte stream into framed commands.
// Each command byte is looked up in a fixed parameter-length table. The
// parameter bytes are then collected, and a single-cycle trigger_action_o is
// issued with a stable cmd_o/params_o. Malformed traffic raises a sticky
// err_code_o.
// Optional feature: define SPI_CMD_TIMEOUT_EN to build the inter-byte timeout.
module spi_cmd_framer #(
  parameter int unsigned MAX_PARAMS     = 5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd42000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_msg_i,
  input  logic                    byte_valid_i,
  input  logic [7:0]              byte_in_i,
  input  logic                    error_clear_i,
  output logic                    trigger_action_o,
  output logic [7:0]              cmd_o,
  output logic [8*MAX_PARAMS-1:0] params_o,
  output logic                    busy_o,
  output logic [1:0]              err_code_o,
  output logic [7:0]              trig_count_o
);

  localparam int unsigned IdxW = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrUnknown = 2'b01;
  localparam logic [1:0] ErrTrunc   = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      params_q [MAX_PARAMS];
  logic [7:0]      params_d [MAX_PARAMS];
  logic [IdxW-1:0] idx_q, idx_d;
  logic [1:0]      remaining_q, remaining_d;
  logic            trig_q, trig_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      trig_count_q, trig_count_d;
  logic [1:0]      new_err;
  logic            len_known;
  logic [1:0]      len;
  logic            tmo_hit;

  // Parameter-length table for the byte currently on byte_in_i.
  always_comb begin
    len_known = 1'b1;
    len       = 2'd0;
    case (byte_in_i)
      8'd0, 8'd15, 8'd16, 8'd27, 8'd31:         len = 2'd0;
      8'd17:                                    len = 2'd3;
      8'd26, 8'd29, 8'd30, 8'd32, 8'd33, 8'd34: len = 2'd1;
      default:                                  len_known = 1'b0;
    endcase
  end

`ifdef SPI_CMD_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Count idle cycles spent in READ; any byte or any entry into READ restarts it.
  always_comb begin
    tmo_d = 16'd0;
    if (state_q == StRead && state_d == StRead && !byte_valid_i) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  assign tmo_hit = (state_q == StRead) && (tmo_q == TIMEOUT_CYCLES);

  // Timeout counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start_msg_i outranks a same-cycle byte, a byte outranks timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!start_msg_i && byte_valid_i && len_known && (len != 2'd0)) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (start_msg_i) begin
          state_d = StIdle;
        end else if (byte_valid_i) begin
          if (remaining_q == 2'd1) state_d = StIdle;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath next state: command/param capture, trigger, errors.
  always_comb begin
    cmd_d       = cmd_q;
    params_d    = params_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    trig_d      = 1'b0;
    new_err     = ErrNone;
    case (state_q)
      StIdle: begin
        if (!start_msg_i && byte_valid_i) begin
          cmd_d = byte_in_i;
          idx_d = '0;
          if (!len_known) begin
            new_err = ErrUnknown;
          end else if (len == 2'd0) begin
            trig_d = 1'b1;
          end else begin
            remaining_d = len;
          end
        end
      end
      StRead: begin
        if (start_msg_i) begin
          new_err = ErrTrunc;
        end else if (byte_valid_i) begin
          params_d[idx_q] = byte_in_i;
          idx_d           = idx_q + 1'b1;
          if (remaining_q == 2'd1) begin
            trig_d = 1'b1;
          end else begin
            remaining_d = remaining_q - 2'd1;
          end
        end else if (tmo_hit) begin
          new_err = ErrTimeout;
        end
      end
      default: ;
    endcase

    // Sticky first error; a clear in the same cycle as a new error keeps the new one.
    err_d = error_clear_i ? ErrNone : err_q;
    if (new_err != ErrNone && (err_q == ErrNone || error_clear_i)) begin
      err_d = new_err;
    end

    trig_count_d = trig_d ? trig_count_q + 8'd1 : trig_count_q;
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_q        <= 8'h00;
      idx_q        <= '0;
      remaining_q  <= 2'd0;
      trig_q       <= 1'b0;
      err_q        <= ErrNone;
      trig_count_q <= 8'd0;
      for (int i = 0; i < int'(MAX_PARAMS); i++) params_q[i] <= 8'h00;
    end else begin
      cmd_q        <= cmd_d;
      idx_q        <= idx_d;
      remaining_q  <= remaining_d;
      trig_q       <= trig_d;
      err_q        <= err_d;
      trig_count_q <= trig_count_d;
      for (int i = 0; i < int'(MAX_PARAMS); i++) params_q[i] <= params_d[i];
    end
  end

  // Pack the parameter buffer, params[0] in the low byte.
  always_comb begin
    params_o = '0;
    for (int i = 0; i < int'(MAX_PARAMS); i++) params_o[8*i +: 8] = params_q[i];
  end

  assign trigger_action_o = trig_q;
  assign cmd_o            = cmd_q;
  assign busy_o           = (state_q == StRead);
  assign err_code_o       = err_q;
  assign trig_count_o     = trig_count_q;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Directed bench for spi_cmd_framer: a per-cycle vector table and a few
// hand-written multi-cycle sequences (reset mid-frame, counter wrap, timeout).
module tb_spi_cmd_framer;

  localparam int unsigned MaxP = 5;

  logic              clk = 1'b0;
  logic              reset_i, start_msg_i, byte_valid_i, error_clear_i;
  logic [7:0]        byte_in_i;
  logic              trigger_action_o, busy_o;
  logic [7:0]        cmd_o, trig_count_o;
  logic [8*MaxP-1:0] params_o;
  logic [1:0]        err_code_o;

  int checks   = 0;
  int failures = 0;

  spi_cmd_framer #(
    .MAX_PARAMS    (MaxP),
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .start_msg_i     (start_msg_i),
    .byte_valid_i    (byte_valid_i),
    .byte_in_i       (byte_in_i),
    .error_clear_i   (error_clear_i),
    .trigger_action_o(trigger_action_o),
    .cmd_o           (cmd_o),
    .params_o        (params_o),
    .busy_o          (busy_o),
    .err_code_o      (err_code_o),
    .trig_count_o    (trig_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic        bv;
    logic [7:0]  b;
    logic        clr;
    logic        trig;
    logic [7:0]  cmd;
    logic        busy;
    logic [1:0]  err;
    logic [7:0]  cnt;
    logic [23:0] p;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sm, logic bv, logic [7:0] b, logic clr, logic trig,
                              logic [7:0] cmd, logic busy, logic [1:0] err, logic [7:0] cnt,
                              logic [23:0] p);
    vec_t v;
    v.sm = sm; v.bv = bv; v.b = b; v.clr = clr; v.trig = trig;
    v.cmd = cmd; v.busy = busy; v.err = err; v.cnt = cnt; v.p = p;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [39:0] act,
                     input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are read 1 time unit after the edge.
  task automatic apply(input logic sm, input logic bv, input logic [7:0] b, input logic clr);
    start_msg_i   = sm;
    byte_valid_i  = bv;
    byte_in_i     = b;
    error_clear_i = clr;
    @(posedge clk);
    #1;
    start_msg_i   = 1'b0;
    byte_valid_i  = 1'b0;
    byte_in_i     = 8'h00;
    error_clear_i = 1'b0;
  endtask

  task automatic chk_all_reset(input int idx);
    chk("rst_trig", idx, 40'(trigger_action_o), 40'd0);
    chk("rst_cmd", idx, 40'(cmd_o), 40'd0);
    chk("rst_params", idx, 40'(params_o), 40'd0);
    chk("rst_busy", idx, 40'(busy_o), 40'd0);
    chk("rst_err", idx, 40'(err_code_o), 40'd0);
    chk("rst_cnt", idx, 40'(trig_count_o), 40'd0);
  endtask

  int trig_seen;

  initial begin
    reset_i = 1'b1; start_msg_i = 1'b0; byte_valid_i = 1'b0;
    byte_in_i = 8'h00; error_clear_i = 1'b0;

    //                sm    bv    byte   clr   trig  cmd    busy  err    cnt    params[2:0]
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 8'd1, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 8'd1, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 2'd0, 8'd1, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h11, 1'b1, 2'd0, 8'd1, 24'h0000A1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 8'h11, 1'b1, 2'd0, 8'd1, 24'h00B2A1));
    vecs.push_back(mk(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h11, 1'b0, 2'd0, 8'd2, 24'hC3B2A1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 2'd0, 8'd2, 24'hC3B2A1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 2'd1, 8'd2, 24'hC3B2A1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h1A, 1'b0, 1'b0, 8'h1A, 1'b1, 2'd1, 8'd2, 24'hC3B2A1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 8'h1A, 1'b0, 2'd1, 8'd3, 24'hC3B207));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h1A, 1'b0, 2'd0, 8'd3, 24'hC3B207));
    vecs.push_back(mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 2'd0, 8'd3, 24'hC3B207));
    vecs.push_back(mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h11, 1'b1, 2'd0, 8'd3, 24'hC3B255));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 2'd2, 8'd3, 24'hC3B255));
    vecs.push_back(mk(1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 8'h1E, 1'b1, 2'd2, 8'd3, 24'hC3B255));
    vecs.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0, 2'd2, 8'd4, 24'hC3B23C));
    // start_msg_i with a byte in IDLE: byte dropped, no error
    vecs.push_back(mk(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h1E, 1'b0, 2'd2, 8'd4, 24'hC3B23C));
    // clear together with a new error: new error kept
    vecs.push_back(mk(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 8'h05, 1'b0, 2'd1, 8'd4, 24'hC3B23C));
    vecs.push_back(mk(1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 2'd1, 8'd5, 24'hC3B23C));
    vecs.push_back(mk(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h99, 1'b0, 2'd1, 8'd5, 24'hC3B23C));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 2'd0, 8'd5, 24'hC3B23C));
    vecs.push_back(mk(1'b0, 1'b1, 8'h1D, 1'b0, 1'b0, 8'h1D, 1'b1, 2'd0, 8'd5, 24'hC3B23C));
    // start_msg_i with a byte in READ: byte dropped, truncation recorded
    vecs.push_back(mk(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 8'h1D, 1'b0, 2'd2, 8'd5, 24'hC3B23C));
    vecs.push_back(mk(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 8'h20, 1'b1, 2'd2, 8'd5, 24'hC3B23C));
    vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h20, 1'b0, 2'd2, 8'd6, 24'hC3B2FF));
    vecs.push_back(mk(1'b0, 1'b1, 8'h1B, 1'b0, 1'b1, 8'h1B, 1'b0, 2'd2, 8'd7, 24'hC3B2FF));
    vecs.push_back(mk(1'b0, 1'b1, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 2'd2, 8'd8, 24'hC3B2FF));
    vecs.push_back(mk(1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 2'd2, 8'd9, 24'hC3B2FF));
    vecs.push_back(mk(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h77, 1'b0, 2'd2, 8'd9, 24'hC3B2FF));
    vecs.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 1'b0, 8'h21, 1'b1, 2'd2, 8'd9, 24'hC3B2FF));
    vecs.push_back(mk(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h21, 1'b0, 2'd2, 8'd10, 24'hC3B201));
    vecs.push_back(mk(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h22, 1'b1, 2'd2, 8'd10, 24'hC3B201));
    vecs.push_back(mk(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h22, 1'b0, 2'd2, 8'd11, 24'hC3B202));

    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk_all_reset(0);

    foreach (vecs[i]) begin
      apply(vecs[i].sm, vecs[i].bv, vecs[i].b, vecs[i].clr);
      chk("trig", i, 40'(trigger_action_o), 40'(vecs[i].trig));
      chk("cmd", i, 40'(cmd_o), 40'(vecs[i].cmd));
      chk("busy", i, 40'(busy_o), 40'(vecs[i].busy));
      chk("err", i, 40'(err_code_o), 40'(vecs[i].err));
      chk("cnt", i, 40'(trig_count_o), 40'(vecs[i].cnt));
      chk("params", i, 40'(params_o[23:0]), 40'(vecs[i].p));
    end
    chk("params_hi", 0, 40'(params_o[39:24]), 40'd0);

    // Reset in the middle of a frame: everything back to reset values.
    apply(1'b0, 1'b1, 8'h11, 1'b0);
    apply(1'b0, 1'b1, 8'hA1, 1'b0);
    reset_i = 1'b1;
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    reset_i = 1'b0;
    chk_all_reset(1);

    // 257 back-to-back zero-parameter commands: counter wraps to 1.
    trig_seen = 0;
    for (int n = 0; n < 257; n++) begin
      apply(1'b0, 1'b1, 8'h00, 1'b0);
      if (trigger_action_o) trig_seen++;
      if (n == 255) chk("wrap_cnt", n, 40'(trig_count_o), 40'd0);
    end
    chk("wrap_trigs", 0, 40'(trig_seen), 40'd257);
    chk("wrap_cnt", 256, 40'(trig_count_o), 40'd1);

`ifdef SPI_CMD_TIMEOUT_EN
    // Idle too long inside a frame: timeout error, no trigger.
    trig_seen = 0;
    apply(1'b0, 1'b1, 8'h1D, 1'b0);
    for (int n = 0; n < 110; n++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b0);
      if (trigger_action_o) trig_seen++;
    end
    chk("tmo_err", 0, 40'(err_code_o), 40'd3);
    chk("tmo_busy", 0, 40'(busy_o), 40'd0);
    chk("tmo_trigs", 0, 40'(trig_seen), 40'd0);
    chk("tmo_cnt", 0, 40'(trig_count_o), 40'd1);
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    // Final byte one cycle before the terminal count.
    apply(1'b0, 1'b1, 8'h1D, 1'b0);
    repeat (99) apply(1'b0, 1'b0, 8'h00, 1'b0);
    apply(1'b0, 1'b1, 8'h6B, 1'b0);
    chk("tmo99_trig", 0, 40'(trigger_action_o), 40'd1);
    chk("tmo99_p0", 0, 40'(params_o[7:0]), 40'h6B);
    chk("tmo99_err", 0, 40'(err_code_o), 40'd0);
    // Final byte on the terminal-count cycle: the byte wins.
    apply(1'b0, 1'b1, 8'h1D, 1'b0);
    repeat (100) apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("tmo100_busy", 0, 40'(busy_o), 40'd1);
    apply(1'b0, 1'b1, 8'h6C, 1'b0);
    chk("tmo100_trig", 0, 40'(trigger_action_o), 40'd1);
    chk("tmo100_err", 0, 40'(err_code_o), 40'd0);
    chk("tmo100_cnt", 0, 40'(trig_count_o), 40'd3);
`else
    // Without the timeout, READ waits indefinitely.
    trig_seen = 0;
    apply(1'b0, 1'b1, 8'h1D, 1'b0);
    for (int n = 0; n < 200; n++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b0);
      if (trigger_action_o) trig_seen++;
    end
    chk("notmo_busy", 0, 40'(busy_o), 40'd1);
    chk("notmo_err", 0, 40'(err_code_o), 40'd0);
    chk("notmo_trigs", 0, 40'(trig_seen), 40'd0);
    apply(1'b0, 1'b1, 8'h6B, 1'b0);
    chk("notmo_trig", 0, 40'(trigger_action_o), 40'd1);
    chk("notmo_p0", 0, 40'(params_o[7:0]), 40'h6B);
    chk("notmo_cnt", 0, 40'(trig_count_o), 40'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
